ddr_frame_reader: RTL and testbench

- AXI4 read master that fetches one completed camera frame from the DDR double buffer, after the controller has seen the write-side finish.
- Buffer 0 or buffer 1 is selected per request.
- Each 16-beat x 32-bit burst is repacked into one 512-bit beat on a valid/ready stream, with an end-of-frame flag.
- Sits downstream of the camera DDR write path and upstream of the packet generator / accelerator input.

---
 rtl/ddr_frame_reader.sv | 213 +++++++++++++++++++++
 tb/tb_ddr_frame_reader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_reader.sv
// AXI4 read master: fetches one frame from the selected DDR buffer as
// single-outstanding 16x32-bit bursts and repacks each burst into one
// 512-bit stream beat, flagging the final beat of the frame.
module ddr_frame_reader #(
  parameter logic [31:0] BASE_ADDR0   = 32'h2BC0_0000,
  parameter logic [31:0] BASE_ADDR1   = 32'h2BE0_0000,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned FRAME_BURSTS = 9600
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         rd_start_valid,
  output logic         rd_start_ready,
  input  logic         rd_buf_sel,
  output logic         rd_done_valid,
  input  logic         rd_done_ready,
  output logic         rd_err,
  output logic         M_AXI_ARID,
  output logic [31:0]  M_AXI_ARADDR,
  output logic [7:0]   M_AXI_ARLEN,
  output logic [2:0]   M_AXI_ARSIZE,
  output logic [1:0]   M_AXI_ARBURST,
  output logic         M_AXI_ARLOCK,
  output logic [3:0]   M_AXI_ARCACHE,
  output logic [2:0]   M_AXI_ARPROT,
  output logic [3:0]   M_AXI_ARQOS,
  output logic         M_AXI_ARVALID,
  input  logic         M_AXI_ARREADY,
  input  logic         M_AXI_RID,
  input  logic [31:0]  M_AXI_RDATA,
  input  logic [1:0]   M_AXI_RRESP,
  input  logic         M_AXI_RLAST,
  input  logic         M_AXI_RVALID,
  output logic         M_AXI_RREADY,
  output logic [511:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last
);

  localparam int unsigned DATA_W = 512;
  localparam int unsigned CNT_W  = 14;
  localparam int unsigned BEAT_W = 4;
  localparam logic [CNT_W-1:0]  LAST_BURST = CNT_W'(FRAME_BURSTS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [31:0]       ADDR_STEP  = 32'(BURST_LEN * 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_OUT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DATA_W-1:0]   asm_w;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic                m_valid_q, m_valid_d;
  logic                start_ready_q, start_ready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                done_valid_q, done_valid_d;
  logic                rd_err_q, rd_err_d;

  // RID carries no information with a single ID; keep it visibly consumed
  logic unused_rid;
  assign unused_rid = M_AXI_RID;

  // Fixed AR attributes
  assign M_AXI_ARID    = 1'b0;
  assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;

  assign M_AXI_ARADDR   = addr_q;
  assign M_AXI_ARVALID  = arvalid_q;
  assign M_AXI_RREADY   = rready_q;
  assign rd_start_ready = start_ready_q;
  assign rd_done_valid  = done_valid_q;
  assign rd_err         = rd_err_q;
  assign m_data         = m_data_q;
  assign m_valid        = m_valid_q;
  assign m_last         = m_last_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    burst_cnt_d = burst_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    full_d      = full_q;
    err_d       = err_q;
    asm_d       = asm_q;
    asm_w       = asm_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q;

    case (state_q)
      S_IDLE: begin
        if (rd_start_valid && start_ready_q) begin
          addr_d      = rd_buf_sel ? BASE_ADDR1 : BASE_ADDR0;
          burst_cnt_d = '0;
          err_d       = 1'b0;
          state_d     = S_AR;
        end
      end
      S_AR: begin
        if (M_AXI_ARREADY) begin
          asm_d      = '0;
          beat_cnt_d = '0;
          full_d     = 1'b0;
          state_d    = S_R;
        end
      end
      S_R: begin
        if (M_AXI_RVALID) begin
          // Beats beyond the 16th are dropped and poison the frame
          if (full_q) begin
            err_d = 1'b1;
          end else begin
            for (int k = 0; k < int'(BURST_LEN); k++) begin
              if (beat_cnt_q == BEAT_W'(k)) asm_w[32*k +: 32] = M_AXI_RDATA;
            end
            if (beat_cnt_q == LAST_BEAT) full_d = 1'b1;
            else beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
          asm_d = asm_w;
          if (M_AXI_RRESP != 2'b00) err_d = 1'b1;
          if (M_AXI_RLAST) begin
            if (beat_cnt_q != LAST_BEAT || full_q) err_d = 1'b1;
            m_data_d  = asm_w;
            m_last_d  = (burst_cnt_q == LAST_BURST);
            m_valid_d = 1'b1;
            state_d   = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            state_d = S_DONE;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            addr_d      = addr_q + ADDR_STEP;
            state_d     = S_AR;
          end
        end
      end
      S_DONE: begin
        if (rd_done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    start_ready_d = (state_d == S_IDLE);
    arvalid_d     = (state_d == S_AR);
    rready_d      = (state_d == S_R);
    done_valid_d  = (state_d == S_DONE);
    rd_err_d      = (state_d == S_DONE) && err_d;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      burst_cnt_q   <= '0;
      beat_cnt_q    <= '0;
      full_q        <= 1'b0;
      err_q         <= 1'b0;
      asm_q         <= '0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      m_valid_q     <= 1'b0;
      start_ready_q <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      done_valid_q  <= 1'b0;
      rd_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      burst_cnt_q   <= burst_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      full_q        <= full_d;
      err_q         <= err_d;
      asm_q         <= asm_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      m_valid_q     <= m_valid_d;
      start_ready_q <= start_ready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      done_valid_q  <= done_valid_d;
      rd_err_q      <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Bench for ddr_frame_reader: AXI read-slave model that pushes the expected
// 512-bit beat at every AR handshake, and a stream sink that pops and compares.
module tb_ddr_frame_reader;

  localparam int unsigned FB = 4;
  localparam logic [31:0] B0 = 32'h2BC0_0000;
  localparam logic [31:0] B1 = 32'h2BE0_0000;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         rd_start_valid, rd_start_ready, rd_buf_sel;
  logic         rd_done_valid, rd_done_ready, rd_err;
  logic         M_AXI_ARID;
  logic [31:0]  M_AXI_ARADDR;
  logic [7:0]   M_AXI_ARLEN;
  logic [2:0]   M_AXI_ARSIZE;
  logic [1:0]   M_AXI_ARBURST;
  logic         M_AXI_ARLOCK;
  logic [3:0]   M_AXI_ARCACHE;
  logic [2:0]   M_AXI_ARPROT;
  logic [3:0]   M_AXI_ARQOS;
  logic         M_AXI_ARVALID, M_AXI_ARREADY;
  logic         M_AXI_RID;
  logic [31:0]  M_AXI_RDATA;
  logic [1:0]   M_AXI_RRESP;
  logic         M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic [511:0] m_data;
  logic         m_valid, m_ready, m_last;

  ddr_frame_reader #(
    .BASE_ADDR0(B0), .BASE_ADDR1(B1), .BURST_LEN(16), .FRAME_BURSTS(FB)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .rd_start_valid(rd_start_valid), .rd_start_ready(rd_start_ready), .rd_buf_sel(rd_buf_sel),
    .rd_done_valid(rd_done_valid), .rd_done_ready(rd_done_ready), .rd_err(rd_err),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] data;
    logic         last;
  } beat_t;

  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Scenario knobs shared with the slave and sink models
  logic [31:0] base_exp = B0;
  logic [15:0] frame_tag = '0;
  int          short_burst = -1;
  int          short_len = 16;
  int          err_burst = -1;
  int          err_beat = -1;
  bit          gap_en = 1'b0;
  int          bp_cycles = 0;
  int          beats_seen = 0;
  int          sl_n = 0;
  int          beat_i = 0;
  bit          sl_active = 1'b0;

  function automatic logic [31:0] word(input int n, input int k);
    return (32'(frame_tag) << 16) | 32'(n * 16 + k);
  endfunction

  // AXI read slave: one burst per AR, expected output beat queued at AR time
  initial begin
    int    cur_burst;
    int    cur_len;
    beat_t b;
    cur_burst = 0;
    cur_len = 16;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST = 1'b0;
    M_AXI_RRESP = 2'b00;
    M_AXI_RDATA = '0;
    M_AXI_RID = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        sl_active = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST = 1'b0;
        continue;
      end
      M_AXI_ARREADY = gap_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sl_active) begin
        M_AXI_RVALID = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        M_AXI_RDATA  = word(cur_burst, beat_i);
        M_AXI_RLAST  = (beat_i == cur_len - 1);
        M_AXI_RRESP  = (cur_burst == err_burst && beat_i == err_beat) ? 2'b10 : 2'b00;
      end else begin
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST = 1'b0;
        M_AXI_RRESP = 2'b00;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        checks++;
        if (M_AXI_ARADDR !== base_exp + 32'(64 * sl_n)) begin
          errors++;
          $display("FAIL araddr burst=%0d got=%h exp=%h", sl_n, M_AXI_ARADDR, base_exp + 32'(64 * sl_n));
        end
        if (sl_n == 0) begin
          checks++;
          if (M_AXI_ARLEN !== 8'd15 || M_AXI_ARSIZE !== 3'b010 || M_AXI_ARBURST !== 2'b01 ||
              M_AXI_ARID !== 1'b0 || M_AXI_ARCACHE !== 4'b0011) begin
            errors++;
            $display("FAIL ar_attr got len=%0d size=%0d burst=%0d id=%0d cache=%0d exp 15/2/1/0/3",
                     M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARID, M_AXI_ARCACHE);
          end
        end
        cur_burst = sl_n;
        cur_len = (sl_n == short_burst) ? short_len : 16;
        b.data = '0;
        for (int k = 0; k < cur_len; k++) b.data[32*k +: 32] = word(sl_n, k);
        b.last = (sl_n == int'(FB) - 1);
        exp_q.push_back(b);
        sl_n++;
        sl_active = 1'b1;
        beat_i = 0;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        if (M_AXI_RLAST) sl_active = 1'b0;
        else beat_i++;
      end
    end
  end

  // Stream sink: optional initial stall, then pop-and-compare on handshake
  initial begin
    beat_t e;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        m_ready = 1'b0;
        continue;
      end
      if (m_valid && bp_cycles > 0) begin
        m_ready = 1'b0;
        bp_cycles--;
        checks++;
        if (exp_q.size() == 0 || m_data !== exp_q[0].data) begin
          errors++;
          $display("FAIL stall_data got=%h", m_data);
        end
        checks++;
        if (M_AXI_RREADY !== 1'b0 || M_AXI_ARVALID !== 1'b0) begin
          errors++;
          $display("FAIL stall_axi got rready=%0d arvalid=%0d exp 0/0", M_AXI_RREADY, M_AXI_ARVALID);
        end
      end else begin
        m_ready = gap_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected got=%h", m_data);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (m_data !== e.data) begin
            errors++;
            $display("FAIL m_data got=%h exp=%h", m_data, e.data);
          end
          checks++;
          if (m_last !== e.last) begin
            errors++;
            $display("FAIL m_last got=%0d exp=%0d", m_last, e.last);
          end
        end
        beats_seen++;
      end
    end
  end

  task automatic start_frame(input logic sel, input logic [15:0] tag);
    bit hs;
    hs = 1'b0;
    sl_n = 0;
    base_exp = sel ? B1 : B0;
    frame_tag = tag;
    beats_seen = 0;
    @(negedge clk);
    rd_buf_sel = sel;
    rd_start_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rd_start_ready) begin
        hs = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rd_start_valid = 1'b0;
    rd_buf_sel = ~sel;
    checks++;
    if (!hs || M_AXI_ARVALID !== 1'b1 || rd_start_ready !== 1'b0) begin
      errors++;
      $display("FAIL start hs=%0d arvalid=%0d ready=%0d exp 1/1/0", hs, M_AXI_ARVALID, rd_start_ready);
    end
  endtask

  task automatic finish_frame(input logic want_err);
    bit hs;
    hs = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (rd_done_valid) begin
        hs = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL done_timeout got rd_done_valid=0 exp 1");
    end
    checks++;
    if (rd_err !== want_err) begin
      errors++;
      $display("FAIL rd_err got=%0d exp=%0d", rd_err, want_err);
    end
    checks++;
    if (beats_seen != int'(FB) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL beat_count got=%0d pending=%0d exp %0d/0", beats_seen, exp_q.size(), FB);
    end
    rd_done_ready = 1'b1;
    @(negedge clk);
    rd_done_ready = 1'b0;
    checks++;
    if (rd_done_valid !== 1'b0 || rd_start_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_ack got done=%0d start_ready=%0d exp 0/1", rd_done_valid, rd_start_ready);
    end
  endtask

  task automatic run_frame(input logic sel, input logic [15:0] tag, input logic want_err);
    start_frame(sel, tag);
    finish_frame(want_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (rd_start_ready !== 1'b0 || M_AXI_ARVALID !== 1'b0 || M_AXI_RREADY !== 1'b0 ||
        m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || rd_done_valid !== 1'b0 ||
        rd_err !== 1'b0 || M_AXI_ARADDR !== 32'h0) begin
      errors++;
      $display("FAIL %s got sr=%0d arv=%0d rr=%0d mv=%0d ml=%0d dv=%0d err=%0d addr=%h data_nz=%0d exp all 0",
               tag, rd_start_ready, M_AXI_ARVALID, M_AXI_RREADY, m_valid, m_last,
               rd_done_valid, rd_err, M_AXI_ARADDR, (m_data != '0));
    end
  endtask

  task automatic test_reset;
    #12;
    check_reset_outputs("reset_state");
    checks++;
    if (M_AXI_ARLEN !== 8'd15 || M_AXI_ARSIZE !== 3'b010 || M_AXI_ARBURST !== 2'b01) begin
      errors++;
      $display("FAIL reset_const got len=%0d size=%0d burst=%0d", M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST);
    end
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%0d exp=1", rd_start_ready);
    end
  endtask

  task automatic test_basic;
    run_frame(1'b0, 16'd0, 1'b0);
  endtask

  task automatic test_buf1;
    run_frame(1'b1, 16'd1, 1'b0);
  endtask

  task automatic test_backpressure;
    bp_cycles = 20;
    run_frame(1'b0, 16'd2, 1'b0);
    bp_cycles = 0;
  endtask

  task automatic test_rresp_err;
    err_burst = 1;
    err_beat = 7;
    run_frame(1'b0, 16'd3, 1'b1);
    err_burst = -1;
    err_beat = -1;
  endtask

  task automatic test_short_burst;
    short_burst = 1;
    short_len = 11;
    run_frame(1'b1, 16'd4, 1'b1);
    short_burst = -1;
    short_len = 16;
    run_frame(1'b1, 16'd5, 1'b0);
  endtask

  task automatic test_reset_mid;
    bit hit;
    hit = 1'b0;
    start_frame(1'b0, 16'd6);
    for (int i = 0; i < 1000; i++) begin
      if (sl_n == 3 && sl_active && beat_i >= 3 && M_AXI_RREADY) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reset_reach got burst=%0d exp R phase of burst 3", sl_n);
    end
    aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    aresetn = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_start_ready !== 1'b1 || M_AXI_ARVALID !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release got ready=%0d arvalid=%0d exp 1/0", rd_start_ready, M_AXI_ARVALID);
    end
    run_frame(1'b0, 16'd7, 1'b0);
  endtask

  task automatic test_back_to_back;
    gap_en = 1'b1;
    run_frame(1'b0, 16'd8, 1'b0);
    run_frame(1'b1, 16'd9, 1'b0);
    gap_en = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    rd_start_valid = 1'b0;
    rd_buf_sel = 1'b0;
    rd_done_ready = 1'b0;
    test_reset;
    test_basic;
    test_buf1;
    test_backpressure;
    test_rresp_err;
    test_short_burst;
    test_reset_mid;
    test_back_to_back;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
